// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates destination tags at issue, captures ALU/memory
// result broadcasts, retires completed entries in program order and answers
// operand tag lookups for the reservation station.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    synchronous clear of all entries
//   issue_op, issue_rd       instruction being issued (op 5'b11111 = none)
//   issue_tag                tag the next accepted issue receives
//   rob_full                 registered; issue is ignored while high
//   alu_des_in/alu_data      ALU result broadcast (tag 0 = idle)
//   memory_des_in/_data      memory result broadcast (tag 0 = idle)
//   lookupN_tag/_ready/_value  combinational operand queries (N = 1, 2)
//   commit_valid/_tag/_rd/_value  registered in-order retirement
module reorder_buffer #(
  parameter int unsigned TAG_W = 3,
  parameter int unsigned DEPTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [4:0]       issue_op,
  input  logic [4:0]       issue_rd,
  output logic [TAG_W-1:0] issue_tag,
  output logic             rob_full,
  input  logic [TAG_W-1:0] alu_des_in,
  input  logic [31:0]      alu_data,
  input  logic [TAG_W-1:0] memory_des_in,
  input  logic [31:0]      memory_data,
  input  logic [TAG_W-1:0] lookup1_tag,
  output logic             lookup1_ready,
  output logic [31:0]      lookup1_value,
  input  logic [TAG_W-1:0] lookup2_tag,
  output logic             lookup2_ready,
  output logic [31:0]      lookup2_value,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_tag,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_value
);

  localparam int unsigned NENT   = 2 ** TAG_W;  // slot 0 exists but is never used
  localparam int unsigned DATA_W = 32;
  localparam logic [4:0]  OP_NONE = 5'b11111;

  logic [NENT-1:0]   valid_q, valid_d, ready_q, ready_d;
  logic [4:0]        op_q    [NENT];
  logic [4:0]        op_d    [NENT];
  logic [4:0]        rd_q    [NENT];
  logic [4:0]        rd_d    [NENT];
  logic [DATA_W-1:0] value_q [NENT];
  logic [DATA_W-1:0] value_d [NENT];
  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic              rob_full_q, rob_full_d;
  logic              commit_valid_q, commit_valid_d;
  logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
  logic [4:0]        commit_rd_q, commit_rd_d;
  logic [DATA_W-1:0] commit_value_q, commit_value_d;
  logic              issue_fire, commit_fire;

  // Pointers live in 1..DEPTH; tag 0 means "no tag".
  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(DEPTH)) ? TAG_W'(1) : p + TAG_W'(1);
  endfunction

  // Stores and branches write no architectural register.
  function automatic logic no_dest(input logic [4:0] op);
    case (op)
      5'b10111, 5'b11000, 5'b11001,
      5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b11010, 5'b11011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Lookup result {ready, value}: stored value, else a same-cycle broadcast.
  function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] tag);
    if (tag == '0 || !valid_q[tag]) return '0;
    if (ready_q[tag])               return {1'b1, value_q[tag]};
    if (alu_des_in == tag)          return {1'b1, alu_data};
    if (memory_des_in == tag)       return {1'b1, memory_data};
    return '0;
  endfunction

  // Next-state: capture, commit, issue, then flush overrides everything.
  always_comb begin
    valid_d        = valid_q;
    ready_d        = ready_q;
    op_d           = op_q;
    rd_d           = rd_q;
    value_d        = value_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_tag_d   = commit_tag_q;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;

    issue_fire  = (issue_op != OP_NONE) && !rob_full_q;
    commit_fire = (count_q != '0) && ready_q[head_q];

    // Only entries valid before this edge can capture; ALU applied last wins.
    for (int unsigned i = 1; i < NENT; i++) begin
      if (valid_q[TAG_W'(i)] && !ready_q[TAG_W'(i)]) begin
        if (memory_des_in == TAG_W'(i)) begin
          ready_d[TAG_W'(i)] = 1'b1;
          value_d[TAG_W'(i)] = memory_data;
        end
        if (alu_des_in == TAG_W'(i)) begin
          ready_d[TAG_W'(i)] = 1'b1;
          value_d[TAG_W'(i)] = alu_data;
        end
      end
    end

    if (commit_fire) begin
      commit_valid_d   = 1'b1;
      commit_tag_d     = head_q;
      commit_rd_d      = no_dest(op_q[head_q]) ? 5'd0 : rd_q[head_q];
      commit_value_d   = value_q[head_q];
      valid_d[head_q]  = 1'b0;
      ready_d[head_q]  = 1'b0;
      head_d           = ptr_inc(head_q);
    end

    if (issue_fire) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = 1'b0;
      op_d[tail_q]    = issue_op;
      rd_d[tail_q]    = issue_rd;
      tail_d          = ptr_inc(tail_q);
    end

    case ({issue_fire, commit_fire})
      2'b10:   count_d = count_q + TAG_W'(1);
      2'b01:   count_d = count_q - TAG_W'(1);
      default: count_d = count_q;
    endcase

    rob_full_d = (count_d == TAG_W'(DEPTH));

    if (flush) begin
      valid_d        = '0;
      ready_d        = '0;
      head_d         = TAG_W'(1);
      tail_d         = TAG_W'(1);
      count_d        = '0;
      rob_full_d     = 1'b0;
      commit_valid_d = 1'b0;
      commit_tag_d   = '0;
      commit_rd_d    = '0;
      commit_value_d = '0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      ready_q        <= '0;
      head_q         <= TAG_W'(1);
      tail_q         <= TAG_W'(1);
      count_q        <= '0;
      rob_full_q     <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
    end else begin
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      rob_full_q     <= rob_full_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
    end
  end

  // Payload storage is qualified by valid/ready, so it needs no reset.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    rd_q    <= rd_d;
    value_q <= value_d;
  end

  assign issue_tag    = tail_q;
  assign rob_full     = rob_full_q;
  assign commit_valid = commit_valid_q;
  assign commit_tag   = commit_tag_q;
  assign commit_rd    = commit_rd_q;
  assign commit_value = commit_value_q;

  assign {lookup1_ready, lookup1_value} = lookup(lookup1_tag);
  assign {lookup2_ready, lookup2_value} = lookup(lookup2_tag);

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a program-order scoreboard of
// issued entries predicts commits, rob_full, issue_tag and lookups.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [4:0]  issue_op, issue_rd;
  logic [2:0]  issue_tag;
  logic        rob_full;
  logic [2:0]  alu_des_in, memory_des_in;
  logic [31:0] alu_data, memory_data;
  logic [2:0]  lookup1_tag, lookup2_tag;
  logic        lookup1_ready, lookup2_ready;
  logic [31:0] lookup1_value, lookup2_value;
  logic        commit_valid;
  logic [2:0]  commit_tag;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;

  reorder_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_op(issue_op), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rob_full(rob_full),
    .alu_des_in(alu_des_in), .alu_data(alu_data),
    .memory_des_in(memory_des_in), .memory_data(memory_data),
    .lookup1_tag(lookup1_tag), .lookup1_ready(lookup1_ready), .lookup1_value(lookup1_value),
    .lookup2_tag(lookup2_tag), .lookup2_ready(lookup2_ready), .lookup2_value(lookup2_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_rd(commit_rd), .commit_value(commit_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  tag;
    logic [4:0]  rd;
    logic [31:0] value;
    bit          rdy;
  } rob_rec_t;

  rob_rec_t    sb[$];
  logic [2:0]  m_tail = 3'd1;
  bit          m_full = 1'b0;
  logic        e_cv = 1'b0;
  logic [2:0]  e_tag = 3'd0;
  logic [4:0]  e_rd = 5'd0;
  logic [31:0] e_val = 32'd0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_no_dest(input logic [4:0] op);
    return op inside {5'b10111, 5'b11000, 5'b11001, 5'b01010, 5'b01011,
                      5'b01100, 5'b01101, 5'b11010, 5'b11011};
  endfunction

  function automatic logic [32:0] model_lookup(input logic [2:0] t);
    if (t == 3'd0) return 33'd0;
    foreach (sb[i]) begin
      if (sb[i].tag == t) begin
        if (sb[i].rdy)          return {1'b1, sb[i].value};
        if (alu_des_in == t)    return {1'b1, alu_data};
        if (memory_des_in == t) return {1'b1, memory_data};
        return 33'd0;
      end
    end
    return 33'd0;
  endfunction

  // Advance the reference model across one clock edge using current inputs.
  task automatic model_edge();
    bit acc, cm;
    rob_rec_t r;
    if (rst || flush) begin
      sb.delete();
      m_tail = 3'd1; m_full = 1'b0;
      e_cv = 1'b0; e_tag = 3'd0; e_rd = 5'd0; e_val = 32'd0;
      return;
    end
    acc = (issue_op != 5'b11111) && !m_full;
    cm  = (sb.size() > 0) && sb[0].rdy;
    if (cm) begin
      e_cv = 1'b1; e_tag = sb[0].tag; e_rd = sb[0].rd; e_val = sb[0].value;
    end else begin
      e_cv = 1'b0;
    end
    foreach (sb[i]) begin
      if (!sb[i].rdy) begin
        if (alu_des_in != 3'd0 && sb[i].tag == alu_des_in) begin
          sb[i].rdy = 1'b1; sb[i].value = alu_data;
        end else if (memory_des_in != 3'd0 && sb[i].tag == memory_des_in) begin
          sb[i].rdy = 1'b1; sb[i].value = memory_data;
        end
      end
    end
    if (cm) void'(sb.pop_front());
    if (acc) begin
      r.tag = m_tail; r.rd = is_no_dest(issue_op) ? 5'd0 : issue_rd;
      r.value = 32'd0; r.rdy = 1'b0;
      sb.push_back(r);
      m_tail = (m_tail == 3'd7) ? 3'd1 : m_tail + 3'd1;
    end
    m_full = (sb.size() == 7);
  endtask

  task automatic idle_inputs();
    issue_op = 5'b11111; issue_rd = 5'd0; flush = 1'b0;
    alu_des_in = 3'd0; alu_data = 32'd0;
    memory_des_in = 3'd0; memory_data = 32'd0;
    lookup1_tag = 3'($urandom_range(0, 7));
    lookup2_tag = 3'($urandom_range(0, 7));
  endtask

  // One cycle: check lookups mid-cycle, clock the DUT, compare outputs.
  task automatic tick();
    logic [32:0] l1, l2;
    #2;
    l1 = model_lookup(lookup1_tag);
    l2 = model_lookup(lookup2_tag);
    check_eq("lookup1_ready", 32'(lookup1_ready), 32'(l1[32]));
    check_eq("lookup1_value", lookup1_value, l1[31:0]);
    check_eq("lookup2_ready", 32'(lookup2_ready), 32'(l2[32]));
    check_eq("lookup2_value", lookup2_value, l2[31:0]);
    model_edge();
    @(posedge clk); #1;
    idle_inputs();
    check_eq("commit_valid", 32'(commit_valid), 32'(e_cv));
    check_eq("commit_tag", 32'(commit_tag), 32'(e_tag));
    check_eq("commit_rd", 32'(commit_rd), 32'(e_rd));
    check_eq("commit_value", commit_value, e_val);
    check_eq("rob_full", 32'(rob_full), 32'(m_full));
    check_eq("issue_tag", 32'(issue_tag), 32'(m_tail));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] rd);
    issue_op = op; issue_rd = rd; tick();
  endtask

  task automatic alu_bc(input logic [2:0] t, input logic [31:0] d);
    alu_des_in = t; alu_data = d; tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    do_reset();
    check_eq("reset_issue_tag", 32'(issue_tag), 32'd1);
    check_eq("reset_rob_full", 32'(rob_full), 32'd0);

    // Single ADD: broadcast next cycle, commit one cycle later.
    issue(5'b00000, 5'd5);
    alu_bc(3'd1, 32'h1234);
    check_eq("no_early_commit", 32'(commit_valid), 32'd0);
    tick();
    check_eq("add_commit_value", commit_value, 32'h1234);
    check_eq("add_commit_rd", 32'(commit_rd), 32'd5);

    // Fill to full, overflow issue, wrap after one retirement.
    do_reset();
    for (int i = 0; i < 7; i++) issue(5'b00000, 5'(i + 1));
    check_eq("full_after_7", 32'(rob_full), 32'd1);
    issue(5'b00001, 5'd20);
    check_eq("full_tag_wrap", 32'(issue_tag), 32'd1);
    alu_bc(3'd1, 32'hA1);
    tick();
    check_eq("full_cleared", 32'(rob_full), 32'd0);
    issue(5'b00010, 5'd9);
    check_eq("refull", 32'(rob_full), 32'd1);
    // Full buffer rejects issue even in a committing cycle.
    alu_bc(3'd2, 32'hA2);
    issue(5'b00011, 5'd10);
    for (int i = 0; i < 3; i++) tick();

    // Out-of-order completion retires in order.
    do_reset();
    for (int i = 0; i < 3; i++) issue(5'b00000, 5'(i + 11));
    alu_bc(3'd3, 32'h33);
    memory_des_in = 3'd2; memory_data = 32'h22; tick();
    tick();
    alu_bc(3'd1, 32'h11);
    for (int i = 0; i < 4; i++) tick();

    // Store writes no register; same-tag double broadcast picks ALU.
    do_reset();
    issue(5'b11001, 5'd7);
    memory_des_in = 3'd1; memory_data = 32'h5A5A; tick();
    tick();
    check_eq("sw_commit_rd", 32'(commit_rd), 32'd0);
    issue(5'b00000, 5'd4);
    alu_des_in = 3'd2; alu_data = 32'hAAAA;
    memory_des_in = 3'd2; memory_data = 32'hBBBB; tick();
    tick();

    // Lookup bypass of a same-cycle broadcast, tag 0 never ready.
    do_reset();
    issue(5'b00000, 5'd1);
    issue(5'b00000, 5'd2);
    lookup1_tag = 3'd2; lookup2_tag = 3'd0;
    alu_des_in = 3'd2; alu_data = 32'hBEEF;
    #1;
    check_eq("bypass_ready", 32'(lookup1_ready), 32'd1);
    check_eq("bypass_value", lookup1_value, 32'hBEEF);
    check_eq("tag0_ready", 32'(lookup2_ready), 32'd0);
    tick();

    // Flush with entries in flight; later broadcast must not commit.
    do_reset();
    for (int i = 0; i < 4; i++) issue(5'b00000, 5'(i + 1));
    flush = 1'b1; issue_op = 5'b00000; alu_des_in = 3'd1; alu_data = 32'h77; tick();
    check_eq("flush_issue_tag", 32'(issue_tag), 32'd1);
    check_eq("flush_cv", 32'(commit_valid), 32'd0);
    alu_bc(3'd2, 32'h99);
    for (int i = 0; i < 3; i++) tick();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      issue_op = ($urandom_range(0, 3) == 0) ? 5'b11111 : 5'($urandom_range(0, 30));
      issue_rd = 5'($urandom);
      if (sb.size() > 0 && $urandom_range(0, 1) == 1) begin
        alu_des_in = sb[$urandom_range(0, sb.size() - 1)].tag; alu_data = $urandom;
      end
      if ($urandom_range(0, 2) == 0) begin
        memory_des_in = 3'($urandom_range(0, 7)); memory_data = $urandom;
      end
      flush = ($urandom_range(0, 60) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer opposite the reservation station.
- Allocates the 3-bit destination tags (des) that issue sends to the RS.
- Captures results broadcast by ALU and memory on the des/data buses.
- Retires completed entries in program order to the register file, serves operand tag lookups, and back-pressures issue when full.

Parameters:
TAG_W, 3, tag width; tag 0 is reserved for "no tag / value ready".
DEPTH, 7, entry count; must equal 2^TAG_W-1; entry n holds tag n (1..7).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all entries (mispredict recovery)
issue_op  in  5  opcode of instruction being issued; 5'b11111 = no issue
issue_rd  in  5  architectural destination register
issue_tag  out  3  tag the next issue will receive (= tail); meaningful only when rob_full=0
rob_full  out  1  registered; 1 = issue_op is ignored this cycle
alu_des_in  in  3  ALU broadcast tag; 0 = idle
alu_data  in  32  ALU broadcast value
memory_des_in  in  3  memory broadcast tag; 0 = idle
memory_data  in  32  memory broadcast value
lookup1_tag  in  3  operand-1 tag query
lookup1_ready  out  1  combinational: entry done or being broadcast this cycle
lookup1_value  out  32  combinational value for lookup1_tag
lookup2_tag  in  3  operand-2 tag query
lookup2_ready  out  1  as lookup1_ready
lookup2_value  out  32  as lookup1_value
commit_valid  out  1  registered; one retirement this cycle
commit_tag  out  3  tag retired
commit_rd  out  5  destination register; 0 for stores/branches
commit_value  out  32  result value

Behaviour:
- Per entry: valid, ready, op[4:0], rd[4:0], value[31:0]. Pointers head, tail in 1..7; wrap from 7 to 1 (never 0). count 0..7.
- Reset (rst=1 at posedge):
  - head=tail=1, count=0, all valid/ready=0.
  - rob_full=0, commit_valid=0, commit_tag=0, commit_rd=0, commit_value=0.
  - rst has priority over flush, flush over all other activity.
- flush: same state effect as reset; in-flight issue and broadcasts in that cycle are discarded.
- Issue:
  - Accepted when issue_op!=5'b11111 and rob_full==0, judged on the registered value at the edge.
  - Entry[tail]: valid=1, ready=0, op, rd latched; tail advances.
  - There is no same-cycle slot reuse from a simultaneous commit: a full buffer rejects issue even if it commits that cycle.
  - A rejected issue is dropped; the upstream holds issue_op.
- Result capture:
  - For each valid, not-ready entry whose tag equals alu_des_in (nonzero): ready<=1, value<=alu_data.
  - Likewise for memory_des_in.
  - If both buses carry the same tag, alu_data wins (protocol error, must not hang).
  - Broadcasts to invalid or already-ready entries are ignored.
  - An entry issued in cycle N cannot capture a broadcast in cycle N.
- Commit:
  - At each posedge, if count>0 and entry[head].ready: commit_valid<=1, commit_tag<=head, commit_value<=value, commit_rd<=rd.
  - commit_rd is forced to 0 for SB/SH/SW (10111,11000,11001) and BEQ/BGE/BNE/BGEU/BLT/BLTU (01010,01011,01100,01101,11010,11011).
  - entry[head].valid<=0; head advances.
  - Otherwise commit_valid<=0; other commit outputs hold.
  - At most one commit per cycle.
  - A head entry made ready by a broadcast this cycle commits next cycle earliest (1-cycle capture-to-commit latency).
- count: +1 on issue only, -1 on commit only, unchanged on both.
- rob_full<=(count_next==7).
- Lookup, combinational, priority order:
  1. tag 0 or invalid entry -> ready=0, value=0.
  2. Entry ready -> stored value.
  3. Tag matches alu_des_in -> alu_data, ready=1.
  4. Tag matches memory_des_in -> memory_data, ready=1.
  5. Otherwise ready=0, value=0.

Test Plan:
- Reset, issue ADD rd=5 -> issue_tag was 1. ALU broadcasts tag1=0x1234 next cycle -> commit_valid=1, commit_tag=1, commit_rd=5, commit_value=0x1234 one cycle after the broadcast.
- Issue 7 ops without results -> rob_full=1 after the 7th, 8th issue ignored, issue_tag=1. Complete tag1 -> one commit, rob_full=0 next cycle, next issue gets tag 1 (wrap).
- Complete tags 3,2 before 1 -> no commit until tag1 ready, then commits 1,2,3 on consecutive cycles in order.
- Issue SW rd=7 as tag1, memory broadcasts tag1 -> commit_rd=0, commit_valid=1.
- lookup1_tag=2 with entry 2 pending while alu_des_in=2, alu_data=0xBEEF -> lookup1_ready=1, lookup1_value=0xBEEF same cycle; lookup1_tag=0 -> ready=0.
- With 4 entries in flight, assert flush -> next cycle count=0, rob_full=0, commit_valid=0, issue_tag=1; a broadcast on tag 2 afterwards causes no commit.
